fft_frame_sequencer: RTL and testbench
======================================

# fft_frame_sequencer

Sequences the FFT datapath in the DAC-ADC example, in the `ifft_clk` domain. A host start trigger launches a run. The block waits for clock lock, pushes one configuration word to the FFT core, and releases fixed-length sample frames only when the TX FIFO has data and the RX FIFO has space. It then counts result frames back and reports progress and errors in a 32-bit word suitable for a wire-out.

## Interface
- `FRAME_LEN`, 1024: samples per FFT frame, ≥2.
- `FRAME_CNT_W`, 16: width of frame counters and `num_frames`.
- `TIMEOUT_CYCLES`, 1000000: maximum consecutive cycles in a waiting state.
- `ifft_clk` in 1: sole clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle trigger pulse (triggerin bit).
- `abort` in 1: level. Forces the block to IDLE.
- `num_frames` in FRAME_CNT_W: frames per run, latched at accepted start. 0 means continuous until abort.
- `cfg_word` in 8: FFT config (bit0 = forward), latched at accepted start.
- `locked` in 1: clock generator locked.
- `fft_tx_fifo_prog_empty` in 1: TX FIFO below one-frame threshold.
- `fft_rx_fifo_prog_full` in 1: RX FIFO lacks space for one frame.
- `fft_cfg_tvalid` out 1 / `fft_cfg_tready` in 1 / `fft_cfg_tdata` out 8: FFT config channel.
- `stream_en` out 1: gates the TX FIFO→FFT sample path.
- `sample_beat` in 1: one sample accepted by the FFT this cycle.
- `fft_s_tlast` out 1: marks the last sample of the frame.
- `frame_done` in 1: one result frame completed (output tlast accepted).
- `busy` out 1, `done` out 1 (pulse), `err_timeout` out 1 (sticky).
- `status` out 32: [2:0] state, [3] busy, [4] err_timeout, [15:5] 0, [31:16] frames_done (lower 16 bits).

## Operation
- State encoding: IDLE=0, WAIT_LOCK=1, CONFIG=2, ARM=3, STREAM=4, DRAIN=5.
- **IDLE:**
  - `start` && !`abort` latches `num_frames` and `cfg_word`.
  - Clears `frames_done`, issued count, outstanding count and `err_timeout`.
  - Next state is WAIT_LOCK.
- **WAIT_LOCK:** when `locked`, go to CONFIG.
- **CONFIG:**
  - `fft_cfg_tvalid`=1 and `fft_cfg_tdata`=latched cfg.
  - On the `tready` cycle, go to ARM.
- **ARM:** when !`fft_tx_fifo_prog_empty` && !`fft_rx_fifo_prog_full`, go to STREAM. The sample counter clears.
- **STREAM:**
  - `stream_en`=1. Each `sample_beat` increments the sample counter.
  - A beat with counter==FRAME_LEN-1 ends the frame: issued +1, outstanding +1.
  - Then go to ARM if continuous mode or issued<num_frames, else DRAIN.
- **DRAIN:** when outstanding==0, go to IDLE and pulse `done`.
- **Counters:**
  - `frame_done` decrements outstanding and increments `frames_done`. A `frame_done` with outstanding==0 is ignored (no underflow).
  - `frame_done` is counted in every non-IDLE state.
  - A frame-ending beat and `frame_done` in the same cycle leave outstanding unchanged, and `frames_done` still increments.
  - Outstanding is FRAME_CNT_W+1 bits wide. `frames_done` saturates at all-ones.
- **Abort:**
  - `abort` in any non-IDLE state goes to IDLE next cycle, with no DRAIN and no `done`.
  - `fft_cfg_tvalid` may drop without `tready`. This is the only permitted handshake violation.
- `start` outside IDLE is ignored.
- `busy` = state≠IDLE.

## Timing
- **Reset:** state IDLE; every output 0; `status`=0; all counters 0.
- **Start latency:**
  - `start` at cycle 0 → WAIT_LOCK at cycle 1.
  - With `locked` high, CONFIG at cycle 2 with `fft_cfg_tvalid` high.
  - `tready` at cycle 2 → ARM at cycle 3.
- **Stream outputs:**
  - `stream_en` is registered and high exactly while in STREAM. It falls in the cycle after the final beat.
  - `fft_s_tlast` = (state==STREAM && count==FRAME_LEN-1). It is combinational from registers.
- **Done:** `done` is high for exactly one cycle, coincident with the first IDLE cycle after DRAIN.
- **Status:** `status` is registered, one cycle behind state.
- **Reset priority:** `reset` mid-run overrides everything, including `abort` and `start`.

## Configuration
- **`FFT_SEQ_TIMEOUT_EN` defined:**
  - A timeout counter restarts on entry to WAIT_LOCK, CONFIG, ARM or DRAIN.
  - After TIMEOUT_CYCLES consecutive cycles in that state: set `err_timeout`, go to IDLE, no `done`.
  - STREAM is never timed.
- **Undefined:** waits are unbounded, `err_timeout` and `status`[4] are tied 0, and no counter is instantiated.

## Structure
- Package `fft_seq_pkg` holds:
  - The state enum and its encodings.
  - The `status` bit positions.
  - The IDLE/cfg reset constants.
- Sub-module `fft_seq_timeout`: loadable down-counter with `restart` and `expired` signals. It is instantiated only under `FFT_SEQ_TIMEOUT_EN`.

## Test plan
- FRAME_LEN=8, num_frames=2, FIFOs ready, `locked`=1, 16 beats, 2 `frame_done` → `fft_s_tlast` on beats 8 and 16; `done` once; `status`[31:16]=2; state 0.
- `fft_rx_fifo_prog_full` held high 50 cycles in ARM → `stream_en` stays 0; on release `stream_en`=1 the next cycle.
- num_frames=0, 5 frames streamed, then `abort` → IDLE next cycle; no `done`; `frames_done`=5.
- `fft_cfg_tready` held low, TIMEOUT_CYCLES=100, macro defined → `err_timeout`=1 after 100 CONFIG cycles; state IDLE; the next `start` clears it.
- `frame_done` with outstanding==0, plus a frame-ending beat coinciding with `frame_done` → no underflow; outstanding unchanged; `frames_done` +1.
- `reset` asserted mid-STREAM with `start` pulsed in the same cycle → all outputs 0 next cycle; state IDLE.

Source files
------------

// File: rtl/fft_frame_sequencer_pkg.sv
// fft_seq_pkg: shared types and constants for the FFT frame sequencer.
// Holds the FSM state encoding, the status word bit map and reset constants.
package fft_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_CONFIG    = 3'd2,
        ST_ARM       = 3'd3,
        ST_STREAM    = 3'd4,
        ST_DRAIN     = 3'd5
    } seq_state_e;

    // Status word bit positions
    localparam int STAT_STATE_LSB = 0;
    localparam int STAT_STATE_MSB = 2;
    localparam int STAT_BUSY_BIT  = 3;
    localparam int STAT_TMO_BIT   = 4;
    localparam int STAT_FD_LSB    = 16;
    localparam int STAT_FD_MSB    = 31;

    // Reset values
    localparam seq_state_e STATE_RST = ST_IDLE;
    localparam logic [7:0] CFG_RST   = 8'h00;

    // Assemble the 32-bit status word; unused bits stay zero
    function automatic logic [31:0] pack_status(input seq_state_e st,
                                                input logic       busy,
                                                input logic       err,
                                                input logic [15:0] frames);
        logic [31:0] s;
        s = 32'h0000_0000;
        s[STAT_STATE_MSB:STAT_STATE_LSB] = st;
        s[STAT_BUSY_BIT]                 = busy;
        s[STAT_TMO_BIT]                  = err;
        s[STAT_FD_MSB:STAT_FD_LSB]       = frames;
        return s;
    endfunction

endpackage

// File: rtl/fft_frame_sequencer_if.sv
// Control / handshake bundle between the FFT frame sequencer and its
// surroundings. The sequencer uses the master modport, the environment
// (host, FIFOs, FFT core) uses the slave modport.
interface fft_frame_sequencer_if #(
    parameter int unsigned FRAME_CNT_W = 16
);
    logic                   start;
    logic                   abort;
    logic [FRAME_CNT_W-1:0] num_frames;
    logic [7:0]             cfg_word;
    logic                   locked;
    logic                   fft_tx_fifo_prog_empty;
    logic                   fft_rx_fifo_prog_full;
    logic                   fft_cfg_tvalid;
    logic                   fft_cfg_tready;
    logic [7:0]             fft_cfg_tdata;
    logic                   stream_en;
    logic                   sample_beat;
    logic                   fft_s_tlast;
    logic                   frame_done;
    logic                   busy;
    logic                   done;
    logic                   err_timeout;
    logic [31:0]            status;

    modport master (
        input  start, abort, num_frames, cfg_word, locked,
               fft_tx_fifo_prog_empty, fft_rx_fifo_prog_full,
               fft_cfg_tready, sample_beat, frame_done,
        output fft_cfg_tvalid, fft_cfg_tdata, stream_en, fft_s_tlast,
               busy, done, err_timeout, status
    );

    modport slave (
        output start, abort, num_frames, cfg_word, locked,
               fft_tx_fifo_prog_empty, fft_rx_fifo_prog_full,
               fft_cfg_tready, sample_beat, frame_done,
        input  fft_cfg_tvalid, fft_cfg_tdata, stream_en, fft_s_tlast,
               busy, done, err_timeout, status
    );
endinterface

// File: rtl/fft_frame_sequencer_timeout.sv
// fft_seq_timeout: loadable down-counter bounding time spent in a wait state.
// Only compiled when FFT_SEQ_TIMEOUT_EN is defined; otherwise the sequencer
// has no timer at all.
// o_expired is high in the CYCLES-th consecutive enabled cycle after a restart.
`ifdef FFT_SEQ_TIMEOUT_EN
module fft_seq_timeout #(
    parameter int unsigned CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_restart,
    input  logic i_enable,
    output logic o_expired
);
    localparam int unsigned      CNT_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD     = CNT_W'((CYCLES > 1) ? (CYCLES - 2) : 0);
    localparam logic             ONE_SHOT = (CYCLES <= 1);

    logic [CNT_W-1:0] r_cnt;

    // Reload on restart (first cycle of a state), then count down while enabled
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_restart) begin
            r_cnt <= LOAD;
        end else if (i_enable && (r_cnt != {CNT_W{1'b0}})) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_expired = i_enable && (i_restart ? ONE_SHOT : (r_cnt == {CNT_W{1'b0}}));
endmodule
`endif

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: launches an FFT run, configures the core, releases
// sample frames when both FIFOs allow it and counts result frames back.
// Optional feature macro: FFT_SEQ_TIMEOUT_EN (bounded waits with err_timeout).
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int unsigned FRAME_LEN      = 1024,
    parameter int unsigned FRAME_CNT_W    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  ifft_clk,
    input  logic                  reset,
    fft_frame_sequencer_if.master bus
);
    localparam int unsigned      SMP_W    = $clog2(FRAME_LEN);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(FRAME_LEN - 1);

    seq_state_e             r_state;
    logic [FRAME_CNT_W-1:0] r_num_frames;
    logic [7:0]             r_cfg;
    logic [SMP_W-1:0]       r_sample_cnt;
    logic [FRAME_CNT_W-1:0] r_issued;
    logic [FRAME_CNT_W:0]   r_outstanding;
    logic [FRAME_CNT_W-1:0] r_frames_done;
    logic                   r_err_timeout;
    logic                   r_stream_en;
    logic                   r_cfg_tvalid;
    logic                   r_done;
    logic [31:0]            r_status;

    logic                   w_frame_end;
    logic                   w_fd_accept;
    logic                   w_more_frames;
    logic                   w_tmo_expired;
    logic [FRAME_CNT_W:0]   w_issued_next;
    logic [15:0]            w_frames16;

    assign w_frame_end   = (r_state == ST_STREAM) && bus.sample_beat && (r_sample_cnt == SMP_LAST);
    // A result frame is only accepted if something is outstanding, or one is issued this same cycle
    assign w_fd_accept   = bus.frame_done && (r_state != ST_IDLE) &&
                           ((r_outstanding != {(FRAME_CNT_W+1){1'b0}}) || w_frame_end);
    assign w_issued_next = {1'b0, r_issued} + {{FRAME_CNT_W{1'b0}}, 1'b1};
    assign w_more_frames = (r_num_frames == {FRAME_CNT_W{1'b0}}) ||
                           (w_issued_next < {1'b0, r_num_frames});
    assign w_frames16    = 16'(r_frames_done);

`ifdef FFT_SEQ_TIMEOUT_EN
    seq_state_e r_state_d;
    logic       w_tmo_restart;
    logic       w_tmo_enable;

    // Previous state, so entry into any new state restarts the wait timer
    always_ff @(posedge ifft_clk) begin
        if (reset) begin
            r_state_d <= STATE_RST;
        end else begin
            r_state_d <= r_state;
        end
    end

    assign w_tmo_restart = (r_state != r_state_d);
    assign w_tmo_enable  = (r_state == ST_WAIT_LOCK) || (r_state == ST_CONFIG) ||
                           (r_state == ST_ARM)       || (r_state == ST_DRAIN);

    fft_seq_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .i_clk     (ifft_clk),
        .i_reset   (reset),
        .i_restart (w_tmo_restart),
        .i_enable  (w_tmo_enable),
        .o_expired (w_tmo_expired)
    );
`else
    assign w_tmo_expired = 1'b0;
`endif

    // Sequencer FSM with its counters and registered outputs
    always_ff @(posedge ifft_clk) begin
        if (reset) begin
            r_state       <= STATE_RST;
            r_num_frames  <= {FRAME_CNT_W{1'b0}};
            r_cfg         <= CFG_RST;
            r_sample_cnt  <= {SMP_W{1'b0}};
            r_issued      <= {FRAME_CNT_W{1'b0}};
            r_outstanding <= {(FRAME_CNT_W+1){1'b0}};
            r_frames_done <= {FRAME_CNT_W{1'b0}};
            r_err_timeout <= 1'b0;
            r_stream_en   <= 1'b0;
            r_cfg_tvalid  <= 1'b0;
            r_done        <= 1'b0;
            r_status      <= 32'h0000_0000;
        end else begin
            r_done       <= 1'b0;
            r_stream_en  <= 1'b0;
            r_cfg_tvalid <= 1'b0;
            r_status     <= pack_status(r_state, (r_state != ST_IDLE), r_err_timeout, w_frames16);

            // Result-frame bookkeeping runs in every active state
            if (r_state != ST_IDLE) begin
                if (w_frame_end && !w_fd_accept) begin
                    r_outstanding <= r_outstanding + {{FRAME_CNT_W{1'b0}}, 1'b1};
                end else if (w_fd_accept && !w_frame_end) begin
                    r_outstanding <= r_outstanding - {{FRAME_CNT_W{1'b0}}, 1'b1};
                end else begin
                    r_outstanding <= r_outstanding;
                end
                if (w_fd_accept && (r_frames_done != {FRAME_CNT_W{1'b1}})) begin
                    r_frames_done <= r_frames_done + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        r_num_frames  <= bus.num_frames;
                        r_cfg         <= bus.cfg_word;
                        r_frames_done <= {FRAME_CNT_W{1'b0}};
                        r_issued      <= {FRAME_CNT_W{1'b0}};
                        r_outstanding <= {(FRAME_CNT_W+1){1'b0}};
                        r_err_timeout <= 1'b0;
                        r_state       <= ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (bus.locked) begin
                        r_cfg_tvalid <= 1'b1;
                        r_state      <= ST_CONFIG;
                    end else if (w_tmo_expired) begin
                        r_err_timeout <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                ST_CONFIG: begin
                    if (bus.fft_cfg_tready) begin
                        r_state <= ST_ARM;
                    end else if (w_tmo_expired) begin
                        r_err_timeout <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_cfg_tvalid <= 1'b1;
                    end
                end
                ST_ARM: begin
                    r_sample_cnt <= {SMP_W{1'b0}};
                    if (!bus.fft_tx_fifo_prog_empty && !bus.fft_rx_fifo_prog_full) begin
                        r_stream_en <= 1'b1;
                        r_state     <= ST_STREAM;
                    end else if (w_tmo_expired) begin
                        r_err_timeout <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    if (w_frame_end) begin
                        r_sample_cnt <= {SMP_W{1'b0}};
                        r_issued     <= w_issued_next[FRAME_CNT_W-1:0];
                        r_state      <= w_more_frames ? ST_ARM : ST_DRAIN;
                    end else begin
                        r_stream_en <= 1'b1;
                        if (bus.sample_beat) begin
                            r_sample_cnt <= r_sample_cnt + SMP_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_outstanding == {(FRAME_CNT_W+1){1'b0}}) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (w_tmo_expired) begin
                        r_err_timeout <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Abort wins over every transition above; tvalid may drop mid-handshake
            if (bus.abort && (r_state != ST_IDLE)) begin
                r_state      <= ST_IDLE;
                r_stream_en  <= 1'b0;
                r_cfg_tvalid <= 1'b0;
                r_done       <= 1'b0;
            end
        end
    end

    assign bus.fft_cfg_tvalid = r_cfg_tvalid;
    assign bus.fft_cfg_tdata  = r_cfg;
    assign bus.stream_en      = r_stream_en;
    assign bus.fft_s_tlast    = (r_state == ST_STREAM) && (r_sample_cnt == SMP_LAST);
    assign bus.busy           = (r_state != ST_IDLE);
    assign bus.done           = r_done;
    assign bus.err_timeout    = r_err_timeout;
    assign bus.status         = r_status;
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with FRAME_LEN=8, TIMEOUT_CYCLES=100.
module tb_fft_frame_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fft_frame_sequencer_if #(.FRAME_CNT_W(16)) bus ();

    fft_frame_sequencer #(
        .FRAME_LEN      (8),
        .FRAME_CNT_W    (16),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .ifft_clk (clk),
        .reset    (reset),
        .bus      (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start pulse, lock already high, cfg accepted on first CONFIG cycle; returns in ARM
    task automatic start_to_arm(input logic [15:0] nf, input logic [7:0] cfg);
        bus.num_frames = nf;
        bus.cfg_word   = cfg;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.fft_cfg_tready = 1'b1;
        tick();
        bus.fft_cfg_tready = 1'b0;
    endtask

    // Feed n beats while stream_en is high; tlast expected on every 8th beat
    task automatic run_beats(input int n, input bit fd_last);
        int b = 0;
        for (int c = 0; (c < 20 * n + 20) && (b < n); c++) begin
            if (bus.stream_en === 1'b1) begin
                bus.sample_beat = 1'b1;
                bus.frame_done  = fd_last && (b == n - 1);
                chk($sformatf("tlast_beat%0d", b + 1), 32'(bus.fft_s_tlast), 32'((b % 8) == 7));
                b++;
            end else begin
                bus.sample_beat = 1'b0;
                bus.frame_done  = 1'b0;
            end
            tick();
        end
        bus.sample_beat = 1'b0;
        bus.frame_done  = 1'b0;
        chk("beat_count", b, n);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        reset                      = 1'b1;
        bus.start                  = 1'b0;
        bus.abort                  = 1'b0;
        bus.num_frames             = 16'd0;
        bus.cfg_word               = 8'h00;
        bus.locked                 = 1'b1;
        bus.fft_tx_fifo_prog_empty = 1'b0;
        bus.fft_rx_fifo_prog_full  = 1'b0;
        bus.fft_cfg_tready         = 1'b0;
        bus.sample_beat            = 1'b0;
        bus.frame_done             = 1'b0;
        tick();
        tick();
        chk("rst_status", bus.status, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_err", 32'(bus.err_timeout), 32'h0);
        chk("rst_stream_en", 32'(bus.stream_en), 32'h0);
        chk("rst_tvalid", 32'(bus.fft_cfg_tvalid), 32'h0);
        chk("rst_tdata", 32'(bus.fft_cfg_tdata), 32'h0);
        chk("rst_tlast", 32'(bus.fft_s_tlast), 32'h0);
        reset = 1'b0;
        tick();

        // A: two frames, start latency, tlast placement, drain and done
        bus.num_frames = 16'd2;
        bus.cfg_word   = 8'hA5;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("A_busy_wait_lock", 32'(bus.busy), 32'h1);
        chk("A_tvalid_wait_lock", 32'(bus.fft_cfg_tvalid), 32'h0);
        tick();
        chk("A_tvalid_config", 32'(bus.fft_cfg_tvalid), 32'h1);
        chk("A_tdata_config", 32'(bus.fft_cfg_tdata), 32'hA5);
        chk("A_status_lag_wl", bus.status, 32'h0000_0009);
        bus.fft_cfg_tready = 1'b1;
        tick();
        bus.fft_cfg_tready = 1'b0;
        chk("A_tvalid_arm", 32'(bus.fft_cfg_tvalid), 32'h0);
        chk("A_status_lag_cfg", bus.status, 32'h0000_000A);
        chk("A_stream_en_arm", 32'(bus.stream_en), 32'h0);
        tick();
        chk("A_stream_en_stream", 32'(bus.stream_en), 32'h1);
        chk("A_status_lag_arm", bus.status, 32'h0000_000B);
        run_beats(16, 1'b0);
        chk("A_stream_en_fell", 32'(bus.stream_en), 32'h0);
        chk("A_busy_drain", 32'(bus.busy), 32'h1);
        bus.frame_done = 1'b1;
        tick();
        tick();
        bus.frame_done = 1'b0;
        chk("A_no_done_yet", 32'(bus.done), 32'h0);
        tick();
        chk("A_done_pulse", 32'(bus.done), 32'h1);
        chk("A_idle_busy", 32'(bus.busy), 32'h0);
        chk("A_status_lag_drain", bus.status, 32'h0002_000D);
        tick();
        chk("A_done_one_cycle", 32'(bus.done), 32'h0);
        chk("A_status_idle", bus.status, 32'h0002_0000);

        // B: RX FIFO full holds ARM; release starts streaming next cycle
        bus.fft_rx_fifo_prog_full = 1'b1;
        start_to_arm(16'd1, 8'h01);
        hi = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.stream_en !== 1'b0) hi++;
        end
        chk("B_stream_en_held_off", hi, 0);
        chk("B_status_arm", bus.status, 32'h0000_000B);
        bus.fft_rx_fifo_prog_full = 1'b0;
        tick();
        chk("B_stream_en_release", 32'(bus.stream_en), 32'h1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("B_abort_busy", 32'(bus.busy), 32'h0);
        chk("B_abort_stream_en", 32'(bus.stream_en), 32'h0);
        chk("B_abort_no_done", 32'(bus.done), 32'h0);

        // C: continuous mode, five frames, then abort
        start_to_arm(16'd0, 8'h00);
        run_beats(40, 1'b0);
        chk("C_still_running", 32'(bus.busy), 32'h1);
        bus.frame_done = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus.frame_done = 1'b0;
        bus.abort      = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("C_abort_busy", 32'(bus.busy), 32'h0);
        chk("C_abort_no_done", 32'(bus.done), 32'h0);
        chk("C_status_lag", bus.status, 32'h0005_000C);
        tick();
        chk("C_no_done_later", 32'(bus.done), 32'h0);
        chk("C_frames_done5", bus.status, 32'h0005_0000);

        // D: stray frame_done ignored; frame end coinciding with frame_done
        bus.num_frames = 16'd1;
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
        bus.frame_done = 1'b1;
        tick();
        bus.frame_done     = 1'b0;
        bus.fft_cfg_tready = 1'b1;
        tick();
        bus.fft_cfg_tready = 1'b0;
        chk("D_stray_fd_ignored", bus.status, 32'h0000_000A);
        run_beats(8, 1'b1);
        chk("D_drain_busy", 32'(bus.busy), 32'h1);
        chk("D_drain_no_done", 32'(bus.done), 32'h0);
        tick();
        chk("D_done", 32'(bus.done), 32'h1);
        chk("D_status_lag", bus.status, 32'h0001_000D);
        tick();
        chk("D_frames_done1", bus.status, 32'h0001_0000);

        // E: tready held low in CONFIG
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("E_tvalid_config", 32'(bus.fft_cfg_tvalid), 32'h1);
        for (int i = 0; i < 99; i++) tick();
        chk("E_busy_at_limit", 32'(bus.busy), 32'h1);
        tick();
`ifdef FFT_SEQ_TIMEOUT_EN
        chk("E_tmo_busy", 32'(bus.busy), 32'h0);
        chk("E_tmo_err", 32'(bus.err_timeout), 32'h1);
        chk("E_tmo_no_done", 32'(bus.done), 32'h0);
        chk("E_tmo_tvalid", 32'(bus.fft_cfg_tvalid), 32'h0);
        tick();
        chk("E_tmo_status", bus.status, 32'h0000_0010);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("E_err_cleared", 32'(bus.err_timeout), 32'h0);
        chk("E_restart_busy", 32'(bus.busy), 32'h1);
`else
        chk("E_wait_busy", 32'(bus.busy), 32'h1);
        chk("E_wait_err", 32'(bus.err_timeout), 32'h0);
        chk("E_wait_tvalid", 32'(bus.fft_cfg_tvalid), 32'h1);
        chk("E_wait_status", bus.status, 32'h0000_000A);
`endif
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("E_abort_busy", 32'(bus.busy), 32'h0);

        // F: reset mid-STREAM together with start
        start_to_arm(16'd2, 8'h3C);
        run_beats(3, 1'b0);
        chk("F_streaming", 32'(bus.stream_en), 32'h1);
        reset     = 1'b1;
        bus.start = 1'b1;
        tick();
        reset     = 1'b0;
        bus.start = 1'b0;
        chk("F_status", bus.status, 32'h0);
        chk("F_busy", 32'(bus.busy), 32'h0);
        chk("F_stream_en", 32'(bus.stream_en), 32'h0);
        chk("F_tlast", 32'(bus.fft_s_tlast), 32'h0);
        chk("F_tvalid", 32'(bus.fft_cfg_tvalid), 32'h0);
        chk("F_tdata", 32'(bus.fft_cfg_tdata), 32'h0);
        chk("F_done", 32'(bus.done), 32'h0);
        chk("F_err", 32'(bus.err_timeout), 32'h0);
        tick();
        chk("F_start_ignored", 32'(bus.busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
